texture_ram: RTL and testbench
==============================

Name: texture_ram

Overview:
- Writable, parametrised successor to the wall-texture ROM. It is populated at runtime through a streaming load port, so synthesised FPGA/ASIC builds behave the same as simulation.
- Serves texel lookups with registered 1-cycle latency, for any number of textures, any power-of-two texture size and any channel depth.
- Sits between the external texture loader (SPI/host bridge) and the raybox pixel colour path.

Parameters:
- CHANNEL_BITS, 2, bits per colour channel; word width W = 3*CHANNEL_BITS.
- TEX_COUNT, 3, number of wall textures stored (wtid 1..TEX_COUNT).
- TEX_BITS, 6, log2 of texture edge; texture is 2^TEX_BITS square, with 2 side variants.
- WTID_BITS, 2, width of wtid input; TEX_COUNT <= 2^WTID_BITS - 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse: begin (or restart) a full load at address 0.
- load_valid  in  1  load_data holds a word.
- load_data  in  W  texel word to write.
- load_ready  out  1  module accepts a word this cycle.
- load_busy  out  1  high while in LOAD.
- load_done  out  1  one-cycle pulse after the last word is written.
- rd_en  in  1  issue a texel read this cycle.
- side  in  1  wall side (selects light/dark variant).
- wtid  in  WTID_BITS  wall texture ID; 0 means no wall.
- col  in  TEX_BITS  texture column.
- row  in  TEX_BITS  texture row.
- val  out  W  texel value, registered.
- val_valid  out  1  val is the result of the read issued the previous cycle.

Behaviour:
- Storage:
  - TEX_COUNT blocks of D = 2^(2*TEX_BITS+1) words (default 3 x 8192).
  - Linear address = (wtid-1)*D + {~side, col, row}; row is the LSBs, so each column scans Y first.
  - Total depth N = TEX_COUNT*D.
- Reset (async, reset_n=0):
  - state=IDLE, load address counter=0.
  - val=0, val_valid=0, load_ready=0, load_busy=0, load_done=0.
  - Memory contents are not cleared.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: load_ready=0. load_start -> LOAD with counter=0.
  - LOAD: load_busy=1, load_ready=1.
    - Each cycle with load_valid=1 writes load_data at the counter and increments the counter.
    - load_valid=0 stalls the load; the counter holds.
    - When the word at address N-1 is accepted -> DONE.
  - DONE: load_done=1 for exactly one cycle, then IDLE. load_ready=0 in DONE.
  - load_start in LOAD: counter resets to 0 and the state stays LOAD. A word presented in that same cycle is written at address 0 and the counter becomes 1.
  - load_start in DONE: ignored; the FSM still goes to IDLE.
  - Reset mid-LOAD: returns to IDLE. Already-written words persist; the remainder is undefined until reloaded.
- Read path (1-cycle latency):
  - rd_en=1 in cycle T -> val and val_valid=1 in cycle T+1.
  - rd_en=0 -> val_valid=0 and val holds its last value.
  - wtid=0 or wtid>TEX_COUNT -> val=0 with val_valid=1; there is no memory access.
  - Reads while load_busy=1: val_valid=1 and val=0. The load has write priority, and there is no read/write collision on the array.
  - Back-to-back reads: one result per cycle, fully pipelined.
- Widths:
  - Address counter width is ceil(log2(N)).
  - wtid-1 is computed in WTID_BITS.
  - No arithmetic wrap: the counter stops at N-1 when leaving LOAD.

Test Plan (bench config TEX_BITS=2, TEX_COUNT=3 -> D=32, N=96):
- Reset held low mid-sim, asserted asynchronously between clock edges -> val=0, val_valid=0, load_busy=0 immediately, without waiting for a clock edge.
- load_start, then 96 words with load_data=addr[5:0] and load_valid=1 continuously -> load_busy high for 96 cycles, load_done pulses once on cycle 97, then IDLE.
- After the load, rd_en with wtid=2, side=0, col=1, row=3 -> next cycle val=(32+16+4+3)=55[5:0]=55, val_valid=1. The same read with side=1 -> val=39.
- Loader deasserts load_valid every other cycle -> 96 writes still complete, load_done arrives after 192 cycles, and the data matches the previous scenario.
- load_start re-pulsed after 40 words, then the full 96 words of pattern 0x3F-addr -> all reads return the new pattern, and load_done pulses only once.
- rd_en with wtid=0, and separately rd_en during LOAD with wtid=1 -> val=0, val_valid=1. A four-cycle back-to-back read burst returns four values on consecutive cycles.

Source files
------------

// File: rtl/texture_ram.sv
// Runtime-loadable wall texture store: streaming load port plus a 1-cycle texel read port.
// Each texture lives in its own bank; the linear load address selects the bank by its upper bits.

module texture_bank #(
    parameter int W  = 6,
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    // Contents are never reset; they persist until reloaded.
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module texture_ram #(
    parameter int CHANNEL_BITS = 2,
    parameter int TEX_COUNT    = 3,
    parameter int TEX_BITS     = 6,
    parameter int WTID_BITS    = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic [3*CHANNEL_BITS-1:0]  load_data,
    output logic                       load_ready,
    output logic                       load_busy,
    output logic                       load_done,
    input  logic                       rd_en,
    input  logic                       side,
    input  logic [WTID_BITS-1:0]       wtid,
    input  logic [TEX_BITS-1:0]        col,
    input  logic [TEX_BITS-1:0]        row,
    output logic [3*CHANNEL_BITS-1:0]  val,
    output logic                       val_valid
);
    localparam int W      = 3*CHANNEL_BITS;
    localparam int OW     = 2*TEX_BITS + 1;
    localparam int D      = 1 << OW;
    localparam int N      = TEX_COUNT * D;
    localparam int AW     = $clog2(N);
    localparam int BW     = (TEX_COUNT > 1) ? $clog2(TEX_COUNT) : 1;
    localparam int STAGES = 1;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    typedef struct packed {
        logic [WTID_BITS-1:0] idx;
        logic [OW-1:0]        off;
    } rd_req_t;

    state_t                       state_q, state_d;
    logic [AW-1:0]                cnt_q, cnt_d;
    logic [AW-1:0]                wr_addr;
    logic [OW+BW-1:0]             wr_addr_x;
    logic                         wr_en;
    logic [TEX_COUNT-1:0]         bank_we;
    logic [TEX_COUNT-1:0][W-1:0]  bank_rdata;
    rd_req_t                      rd_req;
    logic                         rd_hit;
    logic [W-1:0]                 rd_data;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:1]              vld_q;

    // ---------------- load FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                // A restart pulse rewinds to 0 and may still take a word in the same cycle.
                if (load_start) wr_addr = '0;
                cnt_d = wr_addr;
                if (load_valid) begin
                    wr_en = 1'b1;
                    if (wr_addr == LAST) state_d = DONE;
                    else                 cnt_d   = wr_addr + AW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign load_busy  = (state_q == LOAD);
    assign load_ready = (state_q == LOAD);
    assign load_done  = (state_q == DONE);

    // ---------------- banks ----------------
    assign wr_addr_x = (OW+BW)'(wr_addr);
    assign rd_req    = '{idx: wtid - WTID_BITS'(1), off: {~side, col, row}};

    for (genvar k = 0; k < TEX_COUNT; k++) begin : g_bank
        assign bank_we[k] = wr_en && (wr_addr_x[OW+BW-1:OW] == BW'(k));

        texture_bank #(.W(W), .AW(OW)) u_bank (
            .clk   (clk),
            .we    (bank_we[k]),
            .waddr (wr_addr[OW-1:0]),
            .wdata (load_data),
            .raddr (rd_req.off),
            .rdata (bank_rdata[k])
        );
    end

    // wtid 0 and IDs beyond TEX_COUNT match no bank and read as zero.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int k = 0; k < TEX_COUNT; k++) begin
            if (wtid != '0 && rd_req.idx == WTID_BITS'(k)) begin
                rd_hit  = 1'b1;
                rd_data = bank_rdata[k];
            end
        end
    end

    // ---------------- read pipeline ----------------
    assign vld_pipe = {vld_q, rd_en};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            val   <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0]) val <= (rd_hit && !load_busy) ? rd_data : '0;
        end
    end

    assign val_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_texture_ram.sv
// Self-checking bench for texture_ram: directed load scenarios plus randomized reads
// compared against an address-arithmetic model of the texture store.

module tb_texture_ram;
    localparam int CB    = 2;
    localparam int TC    = 3;
    localparam int TBITS = 2;
    localparam int WB    = 2;
    localparam int W     = 3*CB;
    localparam int D     = 1 << (2*TBITS + 1);
    localparam int N     = TC * D;
    localparam int EDGE  = 1 << TBITS;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             load_start = 1'b0;
    logic             load_valid = 1'b0;
    logic [W-1:0]     load_data = '0;
    logic             load_ready, load_busy, load_done;
    logic             rd_en = 1'b0;
    logic             side = 1'b0;
    logic [WB-1:0]    wtid = '0;
    logic [TBITS-1:0] col = '0;
    logic [TBITS-1:0] row = '0;
    logic [W-1:0]     val;
    logic             val_valid;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] mem_m [N];

    texture_ram #(.CHANNEL_BITS(CB), .TEX_COUNT(TC), .TEX_BITS(TBITS), .WTID_BITS(WB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .rd_en      (rd_en),
        .side       (side),
        .wtid       (wtid),
        .col        (col),
        .row        (row),
        .val        (val),
        .val_valid  (val_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Texture w, side s: light variant (side=1) occupies the lower half of each block.
    function automatic logic [W-1:0] ref_read(input int w, input int s, input int c, input int r);
        if (w == 0 || w > TC) return '0;
        return mem_m[(w-1)*D + (s != 0 ? 0 : D/2) + c*EDGE + r];
    endfunction

    function automatic logic [W-1:0] pattern(input int mode, input int a);
        if (mode == 0) return W'(a);
        if (mode == 1) return W'(63 - a);
        return W'($urandom);
    endfunction

    task automatic set_rd(input int w, input int s, input int c, input int r);
        rd_en = 1'b1;
        wtid  = WB'(w);
        side  = 1'(s);
        col   = TBITS'(c);
        row   = TBITS'(r);
    endtask

    task automatic rd_check(input string tag, input int w, input int s, input int c, input int r);
        set_rd(w, s, c, r);
        tick();
        rd_en = 1'b0;
        check(tag, val, ref_read(w, s, c, r));
        check({tag, "_valid"}, val_valid, 1);
    endtask

    task automatic rand_reads(input string tag, input int n);
        for (int i = 0; i < n; i++)
            rd_check(tag, $urandom_range(1, TC), $urandom_range(0, 1),
                     $urandom_range(0, EDGE-1), $urandom_range(0, EDGE-1));
    endtask

    // gap: 0 continuous, 1 valid on odd cycles only, 2 random. restart_at < 0 means no restart.
    task automatic do_load(input int mode, input int gap, input int restart_at,
                           input int exp_cycles, input bit rd_probe);
        int words = 0, cyc = 0, dones = 0, busy_cyc = 0, bad_ready = 0;
        bit restarted = 0, pre, v;
        logic [W-1:0] d;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_busy_start", load_busy, 1);
        while (words < N && cyc < 2000) begin
            v   = (gap == 0) ? 1'b1 : (gap == 1) ? 1'((cyc % 2) == 1) : 1'($urandom_range(0, 1));
            pre = (restart_at >= 0) && !restarted;
            if (pre && words == restart_at) begin
                load_start = 1'b1;
                v = 1'b1;
                restarted = 1'b1;
                words = 0;
                pre = 1'b0;
            end
            d = pre ? W'($urandom) : pattern(mode, words);
            load_valid = v;
            load_data  = d;
            if (rd_probe && cyc == 10) set_rd(1, 1, 2, 1);
            if (load_ready !== 1'b1) bad_ready++;
            if (load_busy === 1'b1) busy_cyc++;
            tick();
            load_start = 1'b0;
            if (v) begin
                mem_m[words] = d;
                words++;
            end
            if (rd_probe && cyc == 10) begin
                rd_en = 1'b0;
                check("rd_during_load_val", val, 0);
                check("rd_during_load_valid", val_valid, 1);
            end
            if (load_done === 1'b1) dones++;
            cyc++;
        end
        load_valid = 1'b0;
        check("load_words", words, N);
        check("load_ready_in_load", bad_ready, 0);
        if (exp_cycles > 0) check("load_busy_cycles", busy_cyc, exp_cycles);
        check("done_state_done", load_done, 1);
        check("done_state_busy", load_busy, 0);
        check("done_state_ready", load_ready, 0);
        // A start pulse while in DONE must be ignored.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("idle_after_done_busy", load_busy, 0);
        if (load_done === 1'b1) dones++;
        tick();
        if (load_done === 1'b1) dones++;
        check("load_done_pulses", dones, 1);
    endtask

    initial begin
        logic [W-1:0] exp_q [$];
        logic [W-1:0] last;
        int w, s, c, r;

        repeat (2) @(posedge clk);
        #1;
        check("rst_val", val, 0);
        check("rst_val_valid", val_valid, 0);
        check("rst_busy", load_busy, 0);
        check("rst_ready", load_ready, 0);
        check("rst_done", load_done, 0);
        #3 reset_n = 1'b1;
        tick();

        // Load 1: data = address, continuous valid, with a read probe while busy.
        do_load(0, 0, -1, N, 1'b1);
        set_rd(2, 0, 1, 3);
        tick();
        rd_en = 1'b0;
        check("dir_side0", val, 55);
        check("dir_side0_valid", val_valid, 1);
        set_rd(2, 1, 1, 3);
        tick();
        rd_en = 1'b0;
        check("dir_side1", val, 39);
        tick();
        check("rd_idle_valid", val_valid, 0);
        check("rd_idle_hold", val, 39);

        // Async reset between edges while a load is starting and val is non-zero.
        set_rd(2, 0, 1, 3);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        rd_en = 1'b0;
        check("pre_rst_val", val, 55);
        check("pre_rst_busy", load_busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_val", val, 0);
        check("async_rst_valid", val_valid, 0);
        check("async_rst_busy", load_busy, 0);
        check("async_rst_ready", load_ready, 0);
        #2 reset_n = 1'b1;
        tick();
        rand_reads("persist_after_rst", 6);

        // Load 2: same data, valid every other cycle.
        do_load(0, 1, -1, 2*N, 1'b0);
        rand_reads("gap_load", 16);

        // Load 3: restart after 40 random words, then inverted pattern.
        do_load(1, 0, 40, 40 + N, 1'b0);
        rand_reads("restart_load", 16);
        set_rd(2, 0, 1, 3);
        tick();
        rd_en = 1'b0;
        check("dir_inverted", val, 8);

        rd_check("wtid0", 0, $urandom_range(0, 1), $urandom_range(0, EDGE-1), $urandom_range(0, EDGE-1));

        // Back-to-back burst: one result per cycle.
        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(1, TC);
            s = $urandom_range(0, 1);
            c = $urandom_range(0, EDGE-1);
            r = $urandom_range(0, EDGE-1);
            set_rd(w, s, c, r);
            exp_q.push_back(ref_read(w, s, c, r));
            tick();
            last = exp_q.pop_front();
            check("burst_val", val, last);
            check("burst_valid", val_valid, 1);
        end
        rd_en = 1'b0;
        tick();
        check("burst_end_valid", val_valid, 0);
        check("burst_end_hold", val, last);

        // Load 4: random data with random stalls.
        do_load(2, 2, -1, -1, 1'b0);
        rand_reads("rand_load", 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=%0d expected=%0d", checks, -1);
        $fatal(1, "timeout");
    end
endmodule
